keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces presses, and keeps the two most recent
//  hex keys as digits s1/s2. It sits directly upstream of display_controller,

---
 rtl/keypad_scanner.sv | 116 +++++++++++
 tb/tb_keypad_scanner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces presses/releases and shifts the two latest hex digits into s1/s2
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       key_valid
);
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  // nibble {r,c} holds code(r,c); row 0 occupies the low 16 bits
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t        state_q, state_d;
  logic [3:0]    row_meta_q, row_s_q;
  logic [1:0]    idx_q, idx_d, r_q, r_d, low_row;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          key_valid_q, key_valid_d, row_hit;
  assign col       = ~(4'b0001 << idx_q);
  assign s1        = s1_q;
  assign s2        = s2_q;
  assign key_valid = key_valid_q;
  assign low_row   = !row_s_q[0] ? 2'd0 : !row_s_q[1] ? 2'd1 : !row_s_q[2] ? 2'd2 : 2'd3;
  assign row_hit   = !row_s_q[r_q];
  assign db_inc    = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    r_d         = r_q;
    scan_cnt_d  = scan_cnt_q;
    db_cnt_d    = db_cnt_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    key_valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        if (scan_cnt_q == SCAN_LAST) begin
          if (row_s_q != 4'hF) begin
            state_d  = DEBOUNCE;
            r_d      = low_row;
            db_cnt_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (!row_hit) begin
          state_d    = SCAN;
          scan_cnt_d = '0;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DB_MAX) begin
            state_d     = HELD;
            s1_d        = s2_q;
            s2_d        = KEYMAP[{r_q, idx_q, 2'b00} +: 4];
            key_valid_d = 1'b1;
          end
        end
      end
      HELD: begin
        if (!row_hit) begin
          state_d  = RELEASE;
          db_cnt_d = '0;
        end
      end
      RELEASE: begin
        if (row_hit) begin
          state_d = HELD;
        end else begin
          db_cnt_d = db_inc;
          if (db_inc == DB_MAX) begin
            state_d    = SCAN;
            idx_d      = idx_q + 1'b1;
            scan_cnt_d = '0;
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
      state_q     <= SCAN;
      idx_q       <= '0;
      r_q         <= '0;
      scan_cnt_q  <= '0;
      db_cnt_q    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      key_valid_q <= 1'b0;
    end else begin
      row_meta_q  <= row;
      row_s_q     <= row_meta_q;
      state_q     <= state_d;
      idx_q       <= idx_d;
      r_q         <= r_d;
      scan_cnt_q  <= scan_cnt_d;
      db_cnt_q    <= db_cnt_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      key_valid_q <= key_valid_d;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with a keypad model shorting driven columns onto rows
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row, col, s1, s2;
  logic        key_valid;
  logic [15:0] keys = '0;
  int checks = 0, failures = 0;
  int kv_cnt = 0, consec = 0;
  logic kv_prev = 1'b0;
  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .s1(s1), .s2(s2), .key_valid(key_valid)
  );
  always #5 clk = ~clk;
  // keys index is r*4+c; a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end
  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (key_valid === 1'b1 && kv_prev) consec++;
    kv_prev = (key_valid === 1'b1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic kv_wait(input int bound, input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, key_valid}, 32'd1);
  endtask
  initial begin
    logic [3:0] e;
    int first;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 4'b1110);
    chk("rst_s1", s1, 0);
    chk("rst_s2", s2, 0);
    chk("rst_kv", key_valid, 0);
    // test 1: idle scan, 4 cycles per column
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      e = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_col", col, e);
    end
    chk("idle_kv", kv_cnt, 0);
    // test 2: key 5 pressed at the last col0 dwell cycle; expect pulse 13 negedges later
    keys[5] = 1'b1;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1 && first == 0) first = i;
    end
    chk("k5_latency", first, 13);
    chk("k5_col_held", col, 4'b1101);
    chk("k5_s2", s2, 4'h5);
    chk("k5_s1", s1, 4'h0);
    keys = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) chk("k5_col_release", col, 4'b1101);
      if (i == 11) chk("k5_col_next", col, 4'b1011);
    end
    #1 chk("k5_pulses", kv_cnt, 1);
    // test 3: 7 then D
    keys[8] = 1'b1;
    kv_wait(40, "k7_timeout");
    chk("k7_s2", s2, 4'h7);
    chk("k7_s1", s1, 4'h5);
    repeat (5) @(negedge clk);
    chk("k7_hold_s2", s2, 4'h7);
    keys = '0;
    repeat (20) @(negedge clk);
    keys[15] = 1'b1;
    kv_wait(40, "kD_timeout");
    chk("kD_s2", s2, 4'hD);
    chk("kD_s1", s1, 4'h7);
    repeat (5) @(negedge clk);
    keys = '0;
    repeat (20) @(negedge clk);
    #1 chk("k7D_pulses", kv_cnt, 3);
    // test 4: bouncing 3 never stable for 8 cycles
    for (int i = 0; i < 15; i++) begin
      keys[2] = 1'b1;
      repeat (3) @(negedge clk);
      keys[2] = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    #1 chk("bounce_pulses", kv_cnt, 3);
    chk("bounce_s1", s1, 4'h7);
    chk("bounce_s2", s2, 4'hD);
    // test 5: A held, 2 pressed meanwhile, both released together
    keys[3] = 1'b1;
    kv_wait(40, "kA_timeout");
    chk("kA_s2", s2, 4'hA);
    chk("kA_s1", s1, 4'hD);
    keys[1] = 1'b1;
    repeat (20) @(negedge clk);
    #1 chk("kA_col_frozen", col, 4'b0111);
    chk("kA_ignore2", kv_cnt, 4);
    keys = '0;
    repeat (30) @(negedge clk);
    #1 chk("kA_pulses", kv_cnt, 4);
    chk("kA_final_s2", s2, 4'hA);
    // test 6: reset in the middle of debouncing F
    keys[14] = 1'b1;
    first = 0;
    while (col == 4'b1011 && first < 20) begin
      @(negedge clk);
      first++;
    end
    first = 0;
    while (col != 4'b1011 && first < 20) begin
      @(negedge clk);
      first++;
    end
    chk("kF_reach_col2", col, 4'b1011);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_col", col, 4'b1110);
    chk("mid_rst_s1", s1, 0);
    chk("mid_rst_s2", s2, 0);
    chk("mid_rst_kv", key_valid, 0);
    keys = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      e = ~(4'b0001 << (k / 4));
      chk("restart_col", col, e);
    end
    repeat (20) @(negedge clk);
    #1 chk("kF_pulses", kv_cnt, 4);
    chk("kF_s2", s2, 0);
    chk("kv_no_consec", consec, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
